// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter: default sizes, requester id and the
// id/issue tag that travels alongside each write until its status comes back.
package fifo_arb_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int NUM_REQ    = 4;
    localparam int ID_W       = $clog2(NUM_REQ);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } wr_tag_t;

    function automatic req_id_t next_id(input req_id_t id);
        return (int'(id) == NUM_REQ - 1) ? '0 : req_id_t'(int'(id) + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; master = arbiter, slave = producers + FIFO.
// Status (resp_*) returns to the producers; no flow control beyond gnt and full/almostfull.
interface fifo_wr_arbiter_if #(
    parameter int W = 16,
    parameter int N = 4
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    gnt;
    logic            wr_en;
    logic [W-1:0]    data_in;
    logic            full;
    logic            almostfull;
    logic            wr_ack;
    logic            overflow;
    logic            resp_valid;
    logic [ID_W-1:0] resp_id;
    logic            resp_ok;

    modport master (
        input  req, req_data, full, almostfull, wr_ack, overflow,
        output gnt, wr_en, data_in, resp_valid, resp_id, resp_ok
    );

    modport slave (
        output req, req_data, full, almostfull, wr_ack, overflow,
        input  gnt, wr_en, data_in, resp_valid, resp_id, resp_ok
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set req at or after ptr, wrapping; purely combinational.
// No state and no backpressure; any=0 means onehot=0.
module rr_pick #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = |req;
        // Walk the rotated order backwards so the candidate nearest ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
            end
        end
        onehot[idx] = any;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port: gnt comb at t, wr_en/data_in at t+1, status at t+3.
// Grants stop on full, or on almostfull while a write is already in flight; pending reqs just wait.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = fifo_arb_pkg::FIFO_WIDTH,
    parameter int NUM_REQ    = fifo_arb_pkg::NUM_REQ,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    fifo_wr_arbiter_if.master bus,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic                  can_issue;
    logic                  grant;
    logic [NUM_REQ-1:0]    pick_oh;
    req_id_t               pick_id;
    logic                  pick_any;

    req_id_t               rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
    wr_tag_t               tag1_q, tag1_d;
    wr_tag_t               tag2_q, tag2_d;
    logic                  resp_valid_q, resp_valid_d;
    req_id_t               resp_id_q, resp_id_d;
    logic                  resp_ok_q, resp_ok_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        // The write held in wr_en_q commits at this edge, which full does not show yet.
        can_issue = rst_n & enable & ~bus.full & ~(bus.almostfull & wr_en_q);
        grant     = can_issue & pick_any;

        rr_ptr_d  = grant ? next_id(pick_id) : rr_ptr_q;
        wr_en_d   = grant;
        data_in_d = grant ? bus.req_data[int'(pick_id)*FIFO_WIDTH +: FIFO_WIDTH] : data_in_q;

        tag1_d.valid = grant;
        tag1_d.id    = grant ? pick_id : '0;
        tag2_d       = tag1_q;

        // A missing ack is reported as a drop, as is an ack contradicted by overflow.
        resp_valid_d = tag2_q.valid;
        resp_id_d    = tag2_q.id;
        resp_ok_d    = tag2_q.valid & bus.wr_ack & ~bus.overflow;

        drop_cnt_d = drop_cnt_q;
        if (tag2_q.valid && !resp_ok_d && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            wr_en_q      <= 1'b0;
            data_in_q    <= '0;
            tag1_q       <= '0;
            tag2_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_ok_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            data_in_q    <= data_in_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_ok_q    <= resp_ok_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.gnt        = grant ? pick_oh : '0;
    assign bus.wr_en      = wr_en_q;
    assign bus.data_in    = data_in_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_ok    = resp_ok_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers and a depth-8 FIFO are modelled here; a negedge monitor
// predicts grants from the round-robin rule and scoreboards writes and status against queues.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] drop_cnt;

    fifo_wr_arbiter_if #(.W(W), .N(N)) bus_if ();

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus_if),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
        int           id;
    } wr_exp_t;

    typedef struct {
        int cyc;
        int id;
    } rsp_exp_t;

    wr_exp_t      wq[$];
    rsp_exp_t     pq[$];
    bit           okq[$];
    logic [N-1:0] gnt_log[$];
    logic [W-1:0] wdat_log[$];
    int           rid_log[$];
    bit           rok_log[$];
    int           wr_count = 0;

    // Reference state: last granted id (next search starts after it), whether a write is in flight.
    int           last_id = N - 1;
    bit           exp_wr_prev = 1'b0;
    int           model_drop = 0;
    logic [N-1:0] last_gnt = '0;

    int           pick;
    logic [N-1:0] eg;
    wr_exp_t      we;
    rsp_exp_t     re;
    bit           eok;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_gnt", bus_if.gnt, 0);
            check("rst_wr_en", bus_if.wr_en, 0);
            check("rst_resp_valid", bus_if.resp_valid, 0);
            check("rst_drop_cnt", drop_cnt, 0);
            wq.delete();
            pq.delete();
            okq.delete();
            last_id     = N - 1;
            exp_wr_prev = 1'b0;
            model_drop  = 0;
            last_gnt    = '0;
        end else begin
            pick = -1;
            eg   = '0;
            if (enable && !bus_if.full && !(bus_if.almostfull && exp_wr_prev)) begin
                for (int k = 1; k <= N; k++) begin
                    if (pick < 0 && bus_if.req[(last_id + k) % N]) pick = (last_id + k) % N;
                end
            end
            if (pick >= 0) begin
                eg[pick] = 1'b1;
                wq.push_back('{cyc + 1, bus_if.req_data[pick*W +: W], pick});
                last_id = pick;
            end
            exp_wr_prev = (pick >= 0);
            check("gnt", bus_if.gnt, eg);
            if (bus_if.gnt != '0) gnt_log.push_back(bus_if.gnt);
            last_gnt = bus_if.gnt;

            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                we = wq.pop_front();
                check("wr_en", bus_if.wr_en, 1);
                check("data_in", bus_if.data_in, we.data);
                pq.push_back('{cyc + 2, we.id});
            end else begin
                check("wr_en_idle", bus_if.wr_en, 0);
            end
            if (bus_if.wr_en) begin
                wr_count++;
                wdat_log.push_back(bus_if.data_in);
            end

            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                re  = pq.pop_front();
                eok = (okq.size() > 0) ? okq.pop_front() : 1'b0;
                check("resp_valid", bus_if.resp_valid, 1);
                check("resp_id", bus_if.resp_id, re.id);
                check("resp_ok", bus_if.resp_ok, eok);
                if (!eok && model_drop < (1 << CW) - 1) model_drop++;
                rid_log.push_back(re.id);
                rok_log.push_back(eok);
            end else begin
                check("resp_valid_idle", bus_if.resp_valid, 0);
            end
            check("drop_cnt", drop_cnt, model_drop);
        end
    end

    // Environment knobs.
    int           new_pct = 0;
    logic [N-1:0] req_mask = '0;
    int           budget = -1;
    int           rd_pct = 0;
    int           drop_pct = 0;
    int           silent_pct = 0;
    bit           force_drop = 1'b0;
    int           en_pct = 100;
    int           fcnt = 0;
    bit           prev_wr = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            fcnt           = 0;
            prev_wr        = 1'b0;
            bus_if.wr_ack  = 1'b0;
            bus_if.overflow = 1'b0;
        end else begin
            bus_if.wr_ack   = 1'b0;
            bus_if.overflow = 1'b0;
            if (prev_wr) begin
                if (fcnt >= DEPTH || force_drop || int'($urandom_range(99)) < drop_pct) begin
                    bus_if.overflow = 1'b1;
                end else if (int'($urandom_range(99)) < silent_pct) begin
                    bus_if.overflow = 1'b0;
                end else begin
                    bus_if.wr_ack = 1'b1;
                    fcnt++;
                end
                okq.push_back(bus_if.wr_ack);
            end
            if (fcnt > 0 && int'($urandom_range(99)) < rd_pct) fcnt--;
            prev_wr = bus_if.wr_en;
        end
        bus_if.full       = (fcnt == DEPTH);
        bus_if.almostfull = (fcnt == DEPTH - 1);
        for (int i = 0; i < N; i++) begin
            if (bus_if.req[i] && last_gnt[i]) bus_if.req[i] = 1'b0;
            if (!bus_if.req[i] && req_mask[i] && budget != 0 && int'($urandom_range(99)) < new_pct) begin
                bus_if.req[i] = 1'b1;
                bus_if.req_data[i*W +: W] = W'($urandom);
                if (budget > 0) budget--;
            end
        end
        if (en_pct < 100) enable = int'($urandom_range(99)) < en_pct;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.req = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        wdat_log.delete();
        rid_log.delete();
        rok_log.delete();
        wr_count = 0;
    endtask

    function automatic logic [N-1:0] glog(input int k);
        return (gnt_log.size() > k) ? gnt_log[k] : '0;
    endfunction

    function automatic int rlog(input int k);
        return (rid_log.size() > k) ? rid_log[k] : -1;
    endfunction

    logic [N-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int           exp_ids [5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bus_if.req = '0;
        bus_if.req_data = '0;
        bus_if.full = 1'b0;
        bus_if.almostfull = 1'b0;
        bus_if.wr_ack = 1'b0;
        bus_if.overflow = 1'b0;

        // Reset held with random inputs, then idle after release.
        repeat (6) begin
            @(posedge clk);
            #1;
            bus_if.req        = N'($urandom);
            bus_if.req_data   = {$urandom, $urandom};
            bus_if.full       = 1'($urandom);
            bus_if.almostfull = 1'($urandom);
            bus_if.wr_ack     = 1'($urandom);
            bus_if.overflow   = 1'($urandom);
            enable            = 1'($urandom);
        end
        bus_if.req = '0;
        bus_if.full = 1'b0;
        bus_if.almostfull = 1'b0;
        bus_if.wr_ack = 1'b0;
        bus_if.overflow = 1'b0;
        enable = 1'b1;
        rst_n = 1'b1;
        repeat (4) step();
        check("idle_writes", wr_count, 0);

        // Single request from producer 2.
        clear_logs();
        bus_if.req_data[2*W +: W] = 16'hA5A5;
        bus_if.req = 4'b0100;
        repeat (6) step();
        check("single_gnt_count", gnt_log.size(), 1);
        check("single_gnt", glog(0), 4'b0100);
        check("single_data", (wdat_log.size() > 0) ? wdat_log[0] : 16'h0, 16'hA5A5);
        check("single_resp_id", rlog(0), 2);
        check("single_resp_ok", (rok_log.size() > 0) ? rok_log[0] : 1'b0, 1);

        // All four held, FIFO drained every cycle: strict rotation.
        do_reset();
        clear_logs();
        req_mask = 4'hF;
        new_pct  = 100;
        rd_pct   = 100;
        repeat (12) step();
        for (int k = 0; k < 5; k++) begin
            check("rr_gnt_seq", glog(k), exp_seq[k]);
            check("rr_resp_id", rlog(k), exp_ids[k]);
        end

        // No reads into a depth-8 FIFO: exactly 8 writes, no overflow.
        req_mask = '0;
        do_reset();
        clear_logs();
        rd_pct   = 0;
        req_mask = 4'hF;
        repeat (30) step();
        check("fill_writes", wr_count, DEPTH);
        check("fill_gnts", gnt_log.size(), DEPTH);
        check("fill_drop_cnt", drop_cnt, 0);

        // Five forced overflows: drop counter saturates at 3.
        req_mask = '0;
        do_reset();
        clear_logs();
        rd_pct     = 100;
        force_drop = 1'b1;
        budget     = 5;
        req_mask   = 4'b0001;
        repeat (20) step();
        check("drop_resp_count", rid_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("drop_resp_ok", (rok_log.size() > k) ? rok_log[k] : 1'b1, 0);
        end
        check("drop_sat", drop_cnt, 3);
        force_drop = 1'b0;
        req_mask   = '0;
        budget     = -1;

        // Reset one cycle after a grant: write discarded, pointer restarts at 0.
        do_reset();
        clear_logs();
        bus_if.req_data[2*W +: W] = 16'h1234;
        bus_if.req = 4'b0100;
        step();
        check("pre_rst_gnt", glog(0), 4'b0100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", bus_if.wr_en, 0);
        step();
        step();
        clear_logs();
        bus_if.req = 4'b1010;
        rst_n = 1'b1;
        repeat (6) step();
        check("post_rst_first_gnt", glog(0), 4'b0010);
        check("post_rst_resp_count", rid_log.size(), 2);
        check("post_rst_first_resp", rlog(0), 1);

        // enable drops the cycle after a grant: that write still reports, nothing else is granted.
        clear_logs();
        bus_if.req = 4'b1111;
        step();
        enable = 1'b0;
        repeat (6) step();
        check("en_off_gnts", gnt_log.size(), 1);
        check("en_off_gnt", glog(0), 4'b0001);
        check("en_off_resp_count", rid_log.size(), 1);
        check("en_off_resp_id", rlog(0), 0);
        enable = 1'b1;

        // Randomized traffic against the reference model.
        req_mask   = 4'hF;
        new_pct    = 40;
        rd_pct     = 50;
        drop_pct   = 5;
        silent_pct = 5;
        en_pct     = 90;
        repeat (600) step();
        req_mask = '0;
        en_pct   = 100;
        enable   = 1'b1;
        rd_pct   = 100;
        repeat (40) step();
        check("drain_writes_pending", wq.size(), 0);
        check("drain_resps_pending", pq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
